// File: rtl/cr_prefix_pkg.sv
// Shared types and defaults for the prefix-table blocks.
package cr_prefix_pkg;

  localparam int unsigned PREFIX_TBL_STARVE_MAX = 8;
  localparam int unsigned STARVE_CW             = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2,
    RESP  = 2'd3
  } tbl_arb_state_e;

endpackage

// File: rtl/cr_prefix_tbl_arb.sv
// Single-port prefix table RAM arbiter: rec sequencer has priority, register
// indirect access wins when rec is idle or after a forced one-cycle stall.
module cr_prefix_tbl_arb
  import cr_prefix_pkg::*;
#(
  parameter int unsigned AW         = 7,
  parameter int unsigned DW         = 896,
  parameter int unsigned STARVE_MAX = PREFIX_TBL_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rec_cs,
  input  logic [AW-1:0] rec_addr,
  output logic [DW-1:0] rec_dout,
  output logic          rec_stall,
  input  logic          regs_req,
  input  logic          regs_wr,
  input  logic [AW-1:0] regs_addr,
  input  logic [DW-1:0] regs_wdata,
  output logic          regs_ack,
  output logic [DW-1:0] regs_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_dout,
  output logic          err_collision
);

  localparam logic [STARVE_CW-1:0] CNT_LIM = STARVE_CW'(STARVE_MAX - 1);

  tbl_arb_state_e       state_q, state_d;
  logic [STARVE_CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 grant, stall_d, resp_wr_q;
  logic [DW-1:0]        rdata_q;

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + STARVE_CW'(1);
  assign rec_dout = ram_dout;

  // Next state, starvation counter and register grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    stall_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (regs_req) begin
          if (!rec_cs) begin
            grant   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = PEND;
            cnt_d   = STARVE_CW'(1);
          end
        end
      end
      PEND: begin
        if (!regs_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!rec_cs) begin
          grant   = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_LIM) begin
          state_d = STALL;
          stall_d = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      STALL: begin
        grant   = 1'b1;
        state_d = RESP;
        cnt_d   = '0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset holds the port on the rec side only
    grant = grant & rst_n;
  end

  // RAM port mux; a stalled rec_cs never reaches the RAM because STALL always grants
  always_comb begin
    ram_cs    = rec_cs;
    ram_we    = 1'b0;
    ram_addr  = rec_addr;
    ram_wdata = '0;
    if (grant) begin
      ram_cs    = 1'b1;
      ram_we    = regs_wr;
      ram_addr  = regs_addr;
      ram_wdata = regs_wdata;
    end
  end

  // Read data is live from the RAM during the ack cycle, then held
  assign regs_rdata = (state_q == RESP) ? (resp_wr_q ? '0 : ram_dout) : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rec_stall     <= 1'b0;
      regs_ack      <= 1'b0;
      resp_wr_q     <= 1'b0;
      rdata_q       <= '0;
      err_collision <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rec_stall <= stall_d;
      regs_ack  <= grant;
      if (grant) resp_wr_q <= regs_wr;
      if (state_q == RESP) rdata_q <= resp_wr_q ? '0 : ram_dout;
      if (state_q == STALL && rec_cs) err_collision <= 1'b1;
    end
  end

endmodule
